// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with valid/ready input and held result.
// Optional build macro BCD_SATURATE_EN: pegs o_bcd at all nines whenever the value exceeds the displayable range.
module bin2bcd_seq #(
   parameter int BIN_WIDTH  = 14,
   parameter int BCD_DIGITS = 4
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [BIN_WIDTH-1:0]      i_bin,
   input  logic                      i_valid,
   output logic                      o_ready,
   output logic [4*BCD_DIGITS-1:0]   o_bcd,
   output logic                      o_valid,
   output logic                      o_ovf
);

   localparam int SCR_W = 4 * (BCD_DIGITS + 1);
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   // Add 3 to every digit that is 5 or more; digits are adjusted independently.
   function automatic logic [SCR_W-1:0] dd_adjust(input logic [SCR_W-1:0] s);
      logic [SCR_W-1:0] r;
      r = s;
      for (int d = 0; d < BCD_DIGITS + 1; d++) begin
         if (s[4*d +: 4] >= 4'd5) begin
            r[4*d +: 4] = s[4*d +: 4] + 4'd3;
         end else begin
            r[4*d +: 4] = s[4*d +: 4];
         end
      end
      return r;
   endfunction

   state_e                    state_q, state_d;
   logic [BIN_WIDTH-1:0]      shift_q, shift_d;
   logic [SCR_W-1:0]          scratch_q, scratch_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [4*BCD_DIGITS-1:0]   bcd_q, bcd_d;
   logic                      valid_q, valid_d;
   logic                      ovf_q, ovf_d;
   logic                      ready_q, ready_d;

   logic [SCR_W-1:0]            adj_s;
   logic [SCR_W+BIN_WIDTH:0]    wide_s;
   logic [SCR_W-1:0]            scratch_nxt_s;
   logic                        ovf_s;
   logic [4*BCD_DIGITS-1:0]     bcd_nxt_s;

   // One adjust-and-shift step of the combined {scratch, shift} register plus FSM next state.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      valid_d   = 1'b0;
      ovf_d     = ovf_q;
      ready_d   = ready_q;

      adj_s         = dd_adjust(scratch_q);
      wide_s        = {adj_s, shift_q, 1'b0};
      scratch_nxt_s = wide_s[SCR_W+BIN_WIDTH-1:BIN_WIDTH];
      // Top bit can only be set by a value beyond five digits; folded into overflow for safety.
      ovf_s         = |{wide_s[SCR_W+BIN_WIDTH], scratch_nxt_s[SCR_W-1:4*BCD_DIGITS]};
`ifdef BCD_SATURATE_EN
      if (ovf_s) begin
         bcd_nxt_s = {BCD_DIGITS{4'h9}};
      end else begin
         bcd_nxt_s = scratch_nxt_s[4*BCD_DIGITS-1:0];
      end
`else
      bcd_nxt_s = scratch_nxt_s[4*BCD_DIGITS-1:0];
`endif

      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               shift_d   = i_bin;
               scratch_d = '0;
               cnt_d     = '0;
               ready_d   = 1'b0;
               state_d   = S_SHIFT;
            end else begin
               ready_d   = 1'b1;
            end
         end
         S_SHIFT: begin
            scratch_d = scratch_nxt_s;
            shift_d   = wide_s[BIN_WIDTH-1:0];
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
               bcd_d   = bcd_nxt_s;
               ovf_d   = ovf_s;
               valid_d = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_DONE: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset also aborts any conversion in flight.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         ready_q   <= ready_d;
      end
   end

   assign o_ready = ready_q;
   assign o_bcd   = bcd_q;
   assign o_valid = valid_q;
   assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver queues expected results on accept, the monitor checks every o_valid.
module tb_bin2bcd_seq;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [13:0] i_bin;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] o_bcd;
   logic        o_valid;
   logic        o_ovf;

   bin2bcd_seq dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .i_bin   (i_bin),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_bcd   (o_bcd),
      .o_valid (o_valid),
      .o_ovf   (o_ovf)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   n_push  = 0;
   int   n_valid = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Independent decimal model used for the extra spot values.
   function automatic logic [16:0] model(input int v);
      int m;
      logic [15:0] b;
      m = v % 10000;
      b = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
`ifdef BCD_SATURATE_EN
      if (v > 9999) b = 16'h9999;
`endif
      return {(v > 9999) ? 1'b1 : 1'b0, b};
   endfunction

   task automatic send(input logic [13:0] b, input logic push, input logic [15:0] eb,
                       input logic eo, output int acc);
      int n;
      n = 0;
      @(negedge sys_clk);
      i_valid = 1'b1;
      i_bin   = b;
      while (o_ready !== 1'b1 && n < 100) begin
         @(negedge sys_clk);
         n++;
      end
      if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
      acc = cyc;
      if (push) begin
         sb.push_back('{eb, eo, acc});
         n_push++;
      end
      @(negedge sys_clk);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge sys_clk);
         #1;
         if (o_valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("bcd", 32'(o_bcd), 32'(e.bcd));
               chk("ovf", 32'(o_ovf), 32'(e.ovf));
               chk("latency", 32'(cyc), 32'(e.acc + 15));
            end
         end
      end
   end

   initial begin : driver
      int a0, a1, n;
      logic [16:0] m;
      int spot[10] = '{1, 9, 10, 99, 100, 999, 1000, 5005, 12345, 8191};

      sys_rst = 1'b1;
      i_valid = 1'b0;
      i_bin   = 14'd0;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      chk("rst_bcd",   32'(o_bcd),   32'h0000);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ovf",   32'(o_ovf),   32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);

      send(14'd0, 1'b1, 16'h0000, 1'b0, a0);
      drain();

      send(14'h04D2, 1'b1, 16'h1234, 1'b0, a0);
      n = 0;
      while (o_ready === 1'b0 && n < 40) begin
         n++;
         @(negedge sys_clk);
      end
      chk("ready_low_cycles", 32'(n), 32'd15);
      drain();

      send(14'd9999, 1'b1, 16'h9999, 1'b0, a0);
`ifdef BCD_SATURATE_EN
      send(14'd16383, 1'b1, 16'h9999, 1'b1, a0);
      send(14'd10000, 1'b1, 16'h9999, 1'b1, a0);
`else
      send(14'd16383, 1'b1, 16'h6383, 1'b1, a0);
      send(14'd10000, 1'b1, 16'h0000, 1'b1, a0);
`endif
      drain();

      // 77 is requested while 42 is still shifting and must wait for the IDLE after DONE.
      send(14'd42, 1'b1, 16'h0042, 1'b0, a0);
      send(14'd77, 1'b1, 16'h0077, 1'b0, a1);
      chk("hold_accept_cycle", 32'(a1), 32'(a0 + 16));
      drain();

      send(14'd5678, 1'b0, 16'h0000, 1'b0, a0);
      repeat (6) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      chk("abort_bcd",   32'(o_bcd),   32'h0000);
      chk("abort_ready", 32'(o_ready), 32'd1);
      chk("abort_valid", 32'(o_valid), 32'd0);
      chk("abort_ovf",   32'(o_ovf),   32'd0);
      repeat (20) @(negedge sys_clk);
      send(14'd5678, 1'b1, 16'h5678, 1'b0, a0);
      drain();

      foreach (spot[i]) begin
         m = model(spot[i]);
         send(14'(spot[i]), 1'b1, m[15:0], m[16], a0);
      end
      drain();
      repeat (20) @(negedge sys_clk);
      chk("valid_count", 32'(n_valid), 32'(n_push));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
